// File: rtl/dmem_pkg.sv
// Shared declarations for the dmem_pipe block.
//   state_t    : controller states (INIT clears the array, RUN serves requests)
//   lane_count : number of byte lanes in a data word of the given width
package dmem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Lane count is DWIDTH/8; a function because DWIDTH is a per-instance parameter.
  function automatic int lane_count(input int dwidth);
    return dwidth / 8;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage, DEPTH x DWIDTH, with a byte-lane synchronous write
// port and a registered read port.
// Ports:
//   clk          : clock
//   we/widx      : write enable and word index
//   wbe/wdata    : per-lane write enables and write data
//   re/ridx      : read enable and word index; rdata loads on the next edge
//   rclr         : clears the read register (takes priority over re)
//   rdata        : registered read data, held while neither re nor rclr
module dmem_array
  import dmem_pkg::*;
#(
  parameter int  DWIDTH = 8,
  parameter int  IWIDTH = 6,
  parameter int  DEPTH  = 64,
  localparam int LANES  = lane_count(DWIDTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IWIDTH-1:0] widx,
  input  logic [LANES-1:0]  wbe,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [IWIDTH-1:0] ridx,
  input  logic              rclr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; the controller clears it word by
  // word during INIT, which keeps this a plain RAM for synthesis.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < LANES; l++) begin
        if (wbe[l]) mem[widx][l*8 +: 8] <= wdata[l*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rclr)    rdata <= '0;
    else if (re) rdata <= mem[ridx];
  end

endmodule

// File: rtl/dmem_pipe.sv
// Pipelined data memory with a power-on clearing phase.
// After reset the controller spends DEPTH cycles in INIT writing zero to every
// word, then enters RUN and accepts one request per cycle. Reads answer one
// cycle after acceptance; out-of-range reads answer with data 0 and an error
// flag; out-of-range writes are dropped.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   req_valid/req_ready        : request handshake (ready only in RUN)
//   req_we, req_addr           : write/read select, byte address
//   req_be, req_wdata          : byte-lane enables and write data
//   rsp_valid                  : one-cycle pulse per accepted read
//   rsp_rdata, rsp_err         : registered read data and out-of-range flag
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int  DWIDTH = 8,
  parameter int  AWIDTH = 8,
  parameter int  WSHIFT = 2,
  parameter int  DEPTH  = 64,
  localparam int LANES  = lane_count(DWIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [LANES-1:0]  req_be,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IWIDTH = AWIDTH - WSHIFT;

  state_t            state_q, state_d;
  logic [IWIDTH-1:0] cnt_q, cnt_d;
  logic [IWIDTH-1:0] idx;
  logic              in_range;
  logic              accept;
  logic              rd_hit;
  logic              rd_miss;

  logic              arr_we;
  logic [IWIDTH-1:0] arr_widx;
  logic [LANES-1:0]  arr_wbe;
  logic [DWIDTH-1:0] arr_wdata;

  logic              rsp_valid_q;
  logic              rsp_err_q;

  // Byte-offset bits below the word index carry no meaning for word storage.
  logic unused_offset;
  assign unused_offset = ^req_addr[WSHIFT-1:0];

  assign idx       = req_addr[AWIDTH-1:WSHIFT];
  assign in_range  = {1'b0, idx} < (IWIDTH+1)'(DEPTH);
  assign req_ready = (state_q == RUN);
  // A request arriving in a reset cycle must leave no trace.
  assign accept    = req_valid && req_ready && !reset;
  assign rd_hit    = accept && !req_we && in_range;
  assign rd_miss   = accept && !req_we && !in_range;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rd_hit || rd_miss;
      rsp_err_q   <= rd_miss;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arr_we    = 1'b0;
    arr_widx  = idx;
    arr_wbe   = req_be;
    arr_wdata = req_wdata;
    unique case (state_q)
      INIT: begin
        arr_we    = 1'b1;
        arr_widx  = cnt_q;
        arr_wbe   = '1;
        arr_wdata = '0;
        cnt_d     = cnt_q + IWIDTH'(1);
        if (cnt_q == IWIDTH'(DEPTH - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        arr_we = accept && req_we && in_range;
      end
      default: state_d = INIT;
    endcase
  end

  // The read register doubles as rsp_rdata: cleared on reset and on an
  // out-of-range read, loaded on an in-range read, held otherwise.
  dmem_array #(
    .DWIDTH(DWIDTH),
    .IWIDTH(IWIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .widx (arr_widx),
    .wbe  (arr_wbe),
    .wdata(arr_wdata),
    .re   (rd_hit),
    .ridx (idx),
    .rclr (reset || rd_miss),
    .rdata(rsp_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule
